// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation datapath and controller.
//   type_state : five 64-bit words x0..x4; x0 sits in the most significant word.
//   round_const: round constant for a given round-constant index.
//   RotA/RotB  : rotate amounts of the linear diffusion layer, per word.
//   fsm_e      : controller state encoding.
package ascon_pack;

  localparam int unsigned NumWords = 5;
  localparam int unsigned WordW    = 64;

  // Packed with ascending word index so that x0 occupies bits 319:256 and a
  // plain concatenation {x0, x1, x2, x3, x4} assigns naturally.
  typedef logic [0:NumWords-1][WordW-1:0] type_state;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_e;

  localparam int unsigned RotA [NumWords] = '{19, 61, 1, 10, 7};
  localparam int unsigned RotB [NumWords] = '{28, 39, 6, 17, 41};

  // c(i) = {0xF - i, i}; e.g. c(0)=0xF0, c(11)=0x4B.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [3:0] hi;
    hi = 4'hF - idx;
    return {hi, idx};
  endfunction

  function automatic logic [WordW-1:0] rotr64(input logic [WordW-1:0] x,
                                              input int unsigned amt);
    return (x >> amt) | (x << (WordW - amt));
  endfunction

endpackage

// File: rtl/ascon_diffusion.sv
// ASCON linear diffusion layer: xi ^= (xi >>> a_i) ^ (xi >>> b_i).
//   state_i : state before diffusion
//   state_o : state after diffusion
module ascon_diffusion
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  for (genvar w = 0; w < NumWords; w++) begin : g_word
    assign state_o[w] = state_i[w] ^ rotr64(state_i[w], RotA[w]) ^ rotr64(state_i[w], RotB[w]);
  end

endmodule

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, substitution, diffusion.
//   state_i : state entering the round
//   const_i : 8-bit round constant, XORed into x2[7:0]
//   state_o : state leaving the round
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [7:0] const_i,
  output type_state  state_o
);

  type_state added;
  type_state subst;

  always_comb begin
    added       = state_i;
    added[2][7:0] = state_i[2][7:0] ^ const_i;
  end

  ascon_sbox_layer u_sbox (
    .state_i (added),
    .state_o (subst)
  );

  ascon_diffusion u_diff (
    .state_i (subst),
    .state_o (state_o)
  );

endmodule

// File: rtl/ascon_sbox_layer.sv
// ASCON 5-bit S-box applied bitsliced across all 64 columns.
//   state_i : state before substitution
//   state_o : state after substitution
// Column j is {x0[j], x1[j], x2[j], x3[j], x4[j]} with x0 as the MSB.
module ascon_sbox_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  logic [WordW-1:0] x0, x1, x2, x3, x4;
  logic [WordW-1:0] t0, t1, t2, t3, t4;

  // Bitsliced form of the S-box: input and output affine layers around a
  // chi-like nonlinear core.
  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2];
    x3 = state_i[3];
    x4 = state_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;

    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;

    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;

    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o = {x0, x1, x2, x3, x4};
  end

endmodule

// File: rtl/ascon_permutation_ctrl.sv
// Sequences the ASCON permutation p^N, one round per clock.
//   clock_i  : rising-edge clock
//   reset_i  : asynchronous active-high reset
//   start_i  : permutation request, accepted when busy_o is low
//   rounds_i : N, clamped to MAX_ROUNDS, sampled with start_i
//   state_i  : input state, sampled with start_i
//   busy_o   : permutation running
//   done_o   : one-cycle pulse, state_o holds the result
//   state_o  : state register, held until the next accepted start
//   round_o  : current round-constant index
module ascon_permutation_ctrl
  import ascon_pack::*;
#(
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output logic       busy_o,
  output logic       done_o,
  output type_state  state_o,
  output logic [3:0] round_o
);

  localparam logic [3:0] MaxRounds = 4'(MAX_ROUNDS);
  localparam logic [3:0] LastIdx   = 4'(MAX_ROUNDS - 1);

  fsm_e       fsm_q;
  type_state  state_q;
  logic [3:0] idx_q;
  logic       busy_q;
  logic       done_q;

  logic [3:0] rounds_clamped;
  logic [3:0] start_idx;
  logic [7:0] rc;
  type_state  round_d;

  // Later-phase calls (p^8, p^6) use the tail of the constant schedule, so
  // the index starts at MAX_ROUNDS - N and always ends at MAX_ROUNDS - 1.
  always_comb begin
    rounds_clamped = (rounds_i > MaxRounds) ? MaxRounds : rounds_i;
    start_idx      = MaxRounds - rounds_clamped;
    rc             = round_const(idx_q);
  end

  ascon_round u_round (
    .state_i (state_q),
    .const_i (rc),
    .state_o (round_d)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle, StDone: begin
          // DONE accepts a start like IDLE so permutations chain without a bubble.
          if (start_i) begin
            state_q <= state_i;
            idx_q   <= start_idx;
            if (rounds_clamped == 4'd0) begin
              fsm_q  <= StDone;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= StRun;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            fsm_q  <= StIdle;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        StRun: begin
          state_q <= round_d;
          if (idx_q == LastIdx) begin
            fsm_q  <= StDone;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        default: begin
          fsm_q  <= StIdle;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign state_o = state_q;
  assign round_o = idx_q;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Scoreboard bench for ascon_permutation_ctrl. A posedge process models which
// starts are accepted and pushes expected results; a negedge monitor compares.
module tb_ascon_permutation_ctrl;
  import ascon_pack::*;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [3:0] rounds_i;
  type_state  state_i;
  logic       busy_o;
  logic       done_o;
  type_state  state_o;
  logic [3:0] round_o;

  ascon_permutation_ctrl #(.MAX_ROUNDS(12)) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .rounds_i (rounds_i),
    .state_i  (state_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .state_o  (state_o),
    .round_o  (round_o)
  );

  always #5 clock_i = ~clock_i;

  // ASCON S-box as a lookup table, column value with x0 as MSB.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  int checks = 0;
  int errors = 0;
  bit finished = 0;

  function automatic logic [63:0] ror(input logic [63:0] x, input int a);
    return (x >> a) | (x << (64 - a));
  endfunction

  function automatic type_state model_round(input type_state s, input int i);
    logic [63:0] x [5];
    logic [4:0]  v;
    logic [7:0]  c;
    type_state   r;
    for (int k = 0; k < 5; k++) x[k] = s[k];
    c = 8'(((15 - i) << 4) | i);
    x[2] = x[2] ^ {56'd0, c};
    for (int j = 0; j < 64; j++) begin
      v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      v = SBOX[v];
      x[0][j] = v[4];
      x[1][j] = v[3];
      x[2][j] = v[2];
      x[3][j] = v[1];
      x[4][j] = v[0];
    end
    x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
    x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
    x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
    x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
    x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    for (int k = 0; k < 5; k++) r[k] = x[k];
    return r;
  endfunction

  function automatic type_state model_perm(input type_state s, input int n);
    type_state r;
    r = s;
    for (int i = 12 - n; i < 12; i++) r = model_round(r, i);
    return r;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard producer ----------------
  typedef struct {
    type_state st;
    int        cyc;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   free_at = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   idx0    = 0;

  always @(posedge clock_i) begin : model
    int   e;
    int   n;
    exp_t x;
    e = cyc + 1;
    cyc <= e;
    if (reset_i) begin
      q.delete();
      free_at <= 0;
      busy_lo <= 1;
      busy_hi <= 0;
    end else if (start_i && e >= free_at) begin
      n = (int'(rounds_i) > 12) ? 12 : int'(rounds_i);
      x.st  = model_perm(state_i, n);
      x.cyc = e + n;
      q.push_back(x);
      free_at <= e + n + 1;
      if (n > 0) begin
        busy_lo <= e;
        busy_hi <= e + n - 1;
        idx0    <= 12 - n;
      end else begin
        busy_lo <= 1;
        busy_hi <= 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock_i) begin : monitor
    bit   exp_busy;
    bit   exp_done;
    exp_t x;
    if (!reset_i && !finished) begin
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", 320'(busy_o), 320'(exp_busy));
      if (exp_busy) chk("round", 320'(round_o), 320'(idx0 + cyc - busy_lo));
      exp_done = (q.size() > 0) && (q[0].cyc == cyc);
      chk("done", 320'(done_o), 320'(exp_done));
      if (exp_done) begin
        x = q.pop_front();
        chk("result", state_o, x.st);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic [3:0] n, input type_state st);
    @(negedge clock_i);
    start_i  = 1'b1;
    rounds_i = n;
    state_i  = st;
    @(negedge clock_i);
    start_i  = 1'b0;
    rounds_i = 4'($urandom);
    state_i  = rand_state();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    type_state init_st;
    type_state a5_st;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    rounds_i = 4'd0;
    state_i  = '0;
    repeat (2) @(negedge clock_i);
    chk("reset_busy", 320'(busy_o), 320'(0));
    chk("reset_done", 320'(done_o), 320'(0));
    chk("reset_state", state_o, 320'(0));
    chk("reset_round", 320'(round_o), 320'(0));
    reset_i = 1'b0;

    // Ascon-128 initialization, then p^6 of the same input.
    init_st = {64'h80400c0600000000, 64'd0, 64'd0, 64'd0, 64'd0};
    pulse(4'd12, init_st);
    repeat (14) @(negedge clock_i);
    pulse(4'd6, init_st);
    repeat (8) @(negedge clock_i);

    // Zero rounds and clamped rounds.
    a5_st = {40{8'hA5}};
    pulse(4'd0, a5_st);
    repeat (2) @(negedge clock_i);
    pulse(4'd15, a5_st);
    repeat (14) @(negedge clock_i);

    // start held high across a p^8; state_i churns while not accepted.
    @(negedge clock_i);
    start_i  = 1'b1;
    rounds_i = 4'd8;
    state_i  = rand_state();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_i);
      state_i = rand_state();
    end
    start_i = 1'b0;
    repeat (12) @(negedge clock_i);

    // Asynchronous reset mid-permutation at round 5.
    pulse(4'd12, rand_state());
    repeat (5) @(posedge clock_i);
    #3;
    reset_i = 1'b1;
    #1;
    chk("async_busy", 320'(busy_o), 320'(0));
    chk("async_done", 320'(done_o), 320'(0));
    chk("async_state", state_o, 320'(0));
    chk("async_round", 320'(round_o), 320'(0));
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    pulse(4'd12, rand_state());
    repeat (14) @(negedge clock_i);

    // Single round on zero state: c=0x4B.
    pulse(4'd1, '0);
    repeat (3) @(negedge clock_i);

    // Random traffic, including starts while busy.
    repeat (400) begin
      @(negedge clock_i);
      start_i  = ($urandom_range(0, 3) == 0);
      rounds_i = 4'($urandom_range(0, 15));
      state_i  = rand_state();
    end
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (16) @(negedge clock_i);
    chk("drain", 320'(q.size()), 320'(0));

    finished = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_ctrl.md
Name: ascon_permutation_ctrl

Overview:
- Sequences the ASCON permutation p^N over the 320-bit state, one round per clock.
- Each round applies three steps: constant addition to x2, then the 5-bit S-box layer, then the linear diffusion layer.
- Owns the state register, the round counter and the round-constant generation.
- Serves the initialization, associated-data, plaintext and finalization phases of the top-level ASCON FSM, which requests p^12, p^8 or p^6 through a start/busy/done handshake.

Parameters:
- MAX_ROUNDS, 12, maximum number of rounds. Round-constant index range is 0..MAX_ROUNDS-1.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request a permutation. Accepted only when busy_o=0.
- rounds_i  in  4  number of rounds N, sampled with start_i.
- state_i  in  type_state (5x64)  input state, sampled with start_i.
- busy_o  out  1  permutation in progress.
- done_o  out  1  one-cycle pulse: state_o holds the result.
- state_o  out  type_state  current state register. Valid when done_o pulses, held until the next accepted start.
- round_o  out  4  current round-constant index, for debug and coverage.

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-permutation):
  - FSM goes to IDLE.
  - busy_o=0, done_o=0, state_o=0, round_o=0, round counter=0.
  - Any in-flight permutation is discarded. No done_o is produced for it.
- FSM states:
  - IDLE: busy_o=0. start_i=1 → load state_i, compute index and last index (below), go to RUN.
  - RUN: busy_o=1. Each cycle: state ← diffusion(substitution(state ^ const(idx))), then idx ← idx+1. When idx equals the last index, go to DONE instead of incrementing.
  - DONE: done_o=1 for exactly one cycle, busy_o=0. A start_i in DONE is accepted exactly as in IDLE (back-to-back permutations, no bubble). Otherwise go to IDLE.
- Round index setup on an accepted start:
  - idx = MAX_ROUNDS − N.
  - last index = MAX_ROUNDS − 1.
- Round constant: c(i) = {4'hF−i[3:0], i[3:0]}. XOR'ed into x2[7:0] only. Examples: c(0)=0xF0, c(4)=0xB4, c(6)=0x96, c(11)=0x4B.
- Constant addition only: x2 ^= c(i), limited to bits 7:0; no other state bits are modified by this step.
- S-box layer: the ASCON 5-bit S-box applied bitsliced on each of the 64 columns. Bit j of x0..x4 forms column j, with x0 as the MSB.
- Diffusion: xi ^= (xi ⋙ a) ^ (xi ⋙ b). Shift pairs: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
- Latency: start accepted at edge T → done_o=1 in cycle T+N+1 (DONE state). state_o carries the result from edge T+N onward.
- Boundary cases:
  - rounds_i=0: go directly to DONE. state_o=state_i unchanged, done_o one cycle after acceptance.
  - rounds_i>MAX_ROUNDS: clamped to MAX_ROUNDS.
  - start_i while busy_o=1: ignored. No queuing, no corruption of the running permutation.
  - state_i and rounds_i are ignored when no start is accepted.
  - A start in DONE discards nothing. The previous result has already been presented with done_o.

Decomposition:
- ascon_pack holds:
  - type_state, a 5x64 array.
  - Round-constant function or table.
  - Shift constants.
  - FSM state enum (IDLE/RUN/DONE).
- Sub-module ascon_round: combinational constant addition + substitution + diffusion, with inputs state_i and const_i. It instantiates the existing diffusion block and a new substitution block.
- The controller contains only registers, counter, FSM and the round-constant mux.

Test Plan:
- Ascon-128 initialization: state_i = {0x80400c0600000000, K0, K1, N0, N1} with K=N=0, rounds_i=12, start at cycle 0.
  - busy_o=1 for cycles 1..12, done_o=1 at cycle 13.
  - state_o matches the golden software model.
  - round_o sequence is 0..11.
- p^6 with the same input: constants applied are 0x96,0x87,0x78,0x69,0x5A,0x4B. done_o at cycle 7; result matches the model.
- rounds_i=0, state_i=all 0xA5 bytes: done_o at cycle 1, state_o equals state_i bit-exact. rounds_i=15 behaves identically to 12.
- start_i held high for the full run of a p^8:
  - only one done_o pulse until DONE is reached, then the second start is accepted in DONE.
  - Two back-to-back results match the model with no idle cycle between them.
- Assert reset_i asynchronously (mid-cycle) at round 5 of p^12: outputs are 0 immediately, and done_o never pulses. A new p^12 after release produces the correct result.
- Zero state with rounds_i=1: state_o equals the single round with c=0x4B computed by the model. Confirms constant position (x2[7:0]) and S-box bit ordering.
